// File: rtl/bcd_to_bin_entry_if.sv
// Keypad entry / conversion-result bundle for bcd_to_bin_entry.
// The master drives the keypad strobes, the slave returns the converted limit and status.
interface bcd_to_bin_entry_if;
    logic [3:0] digit_in;
    logic       digit_stb;
    logic       commit;
    logic       clear;
    logic [6:0] max_count;
    logic       max_valid;
    logic       done;
    logic       busy;
    logic       err;
    logic [1:0] digit_cnt;

    modport master (
        output digit_in, digit_stb, commit, clear,
        input  max_count, max_valid, done, busy, err, digit_cnt
    );

    modport slave (
        input  digit_in, digit_stb, commit, clear,
        output max_count, max_valid, done, busy, err, digit_cnt
    );
endinterface

// File: rtl/bcd_to_bin_entry.sv
// Two-digit BCD keypad entry with a 7-cycle reverse double-dabble conversion to binary.
// The result is held in max_count and only changes when a conversion completes.
module bcd_to_bin_entry (
    input  logic                    CLK,
    input  logic                    RST,
    bcd_to_bin_entry_if.slave       bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ONE  = 2'd1,
        ST_TWO  = 2'd2,
        ST_CONV = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [7:0] r_entry;
    logic [7:0] r_bcd;
    logic [6:0] r_bin;
    logic [2:0] r_iter;
    logic [6:0] r_max_count;
    logic       r_max_valid;
    logic       r_done;
    logic       r_busy;
    logic       r_err;
    logic [1:0] r_digit_cnt;

    logic [7:0]  w_entry_nxt;
    logic        w_err_nxt;
    logic [1:0]  w_digit_cnt_nxt;
    logic        w_start;
    logic        w_finish;
    logic        w_digit_ok;
    logic        w_last_iter;
    logic [14:0] w_shift;
    logic [7:0]  w_bcd_step;
    logic [6:0]  w_bin_step;

    // A BCD nibble that received a high bit from above is worth 8 but should be worth 5.
    function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
        logic [3:0] res;
        if (nib >= 4'd8) begin
            res = nib - 4'd3;
        end else begin
            res = nib;
        end
        return res;
    endfunction

    assign w_digit_ok  = (bus.digit_in <= 4'd9);
    assign w_last_iter = (r_iter == 3'd6);
    assign w_shift     = {r_bcd, r_bin} >> 1;
    assign w_bcd_step  = {dd_adjust(w_shift[14:11]), dd_adjust(w_shift[10:7])};
    assign w_bin_step  = w_shift[6:0];

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; clear outranks commit, which outranks digit_stb.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.clear) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_ONE, ST_TWO: begin
                    if (bus.commit) begin
                        if (r_state != ST_IDLE) begin
                            w_state_nxt = ST_CONV;
                        end else begin
                            w_state_nxt = r_state;
                        end
                    end else if (bus.digit_stb && w_digit_ok) begin
                        if (r_state == ST_IDLE) begin
                            w_state_nxt = ST_ONE;
                        end else begin
                            w_state_nxt = ST_TWO;
                        end
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                ST_CONV: begin
                    if (w_last_iter) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_CONV;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Output / datapath next values derived from the current state and strobes.
    always_comb begin
        w_entry_nxt     = r_entry;
        w_err_nxt       = r_err;
        w_digit_cnt_nxt = r_digit_cnt;
        w_start         = 1'b0;
        w_finish        = 1'b0;
        if (bus.clear) begin
            w_entry_nxt     = 8'd0;
            w_err_nxt       = 1'b0;
            w_digit_cnt_nxt = 2'd0;
        end else begin
            case (r_state)
                ST_IDLE, ST_ONE, ST_TWO: begin
                    if (bus.commit) begin
                        w_start = (r_state != ST_IDLE);
                    end else if (bus.digit_stb) begin
                        if (w_digit_ok) begin
                            w_entry_nxt     = {r_entry[3:0], bus.digit_in};
                            w_digit_cnt_nxt = (r_digit_cnt == 2'd2) ? 2'd2 : (r_digit_cnt + 2'd1);
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end else begin
                        w_start = 1'b0;
                    end
                end
                ST_CONV: begin
                    if (w_last_iter) begin
                        w_finish        = 1'b1;
                        w_entry_nxt     = 8'd0;
                        w_digit_cnt_nxt = 2'd0;
                    end else begin
                        w_finish = 1'b0;
                    end
                    if (!bus.commit && bus.digit_stb) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_err_nxt = r_err;
                    end
                end
                default: begin
                    w_entry_nxt     = 8'd0;
                    w_digit_cnt_nxt = 2'd0;
                end
            endcase
        end
    end

    // Entry, conversion datapath and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_entry     <= 8'd0;
            r_bcd       <= 8'd0;
            r_bin       <= 7'd0;
            r_iter      <= 3'd0;
            r_max_count <= 7'd0;
            r_max_valid <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_digit_cnt <= 2'd0;
        end else begin
            r_entry     <= w_entry_nxt;
            r_err       <= w_err_nxt;
            r_digit_cnt <= w_digit_cnt_nxt;
            r_busy      <= (w_state_nxt == ST_CONV);
            r_done      <= w_finish;
            if (w_start) begin
                r_bcd  <= r_entry;
                r_bin  <= 7'd0;
                r_iter <= 3'd0;
            end else if (r_state == ST_CONV) begin
                r_bcd  <= w_bcd_step;
                r_bin  <= w_bin_step;
                r_iter <= r_iter + 3'd1;
            end else begin
                r_iter <= r_iter;
            end
            if (w_finish) begin
                r_max_count <= w_bin_step;
                r_max_valid <= 1'b1;
            end else begin
                r_max_count <= r_max_count;
            end
        end
    end

    assign bus.max_count = r_max_count;
    assign bus.max_valid = r_max_valid;
    assign bus.done      = r_done;
    assign bus.busy      = r_busy;
    assign bus.err       = r_err;
    assign bus.digit_cnt = r_digit_cnt;

endmodule
